// File: rtl/swi_debouncer_if.sv
// Change-event handshake between the switch debouncer and its consumers.
// master produces events, slave accepts them with evt_ready.
interface swi_debouncer_if #(
    parameter int NBITS = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [NBITS-1:0] evt_bits;
    logic [NBITS-1:0] evt_changed;
    logic             evt_overflow;

    modport master (
        output evt_valid,
        input  evt_ready,
        output evt_bits,
        output evt_changed,
        output evt_overflow
    );

    modport slave (
        input  evt_valid,
        output evt_ready,
        input  evt_bits,
        input  evt_changed,
        input  evt_overflow
    );
endinterface

// File: rtl/swi_debouncer.sv
// Switch conditioner: per-bit synchroniser, debounce filter, edge pulses
// and a coalescing change-event port toward the display stage.
module swi_debouncer #(
    parameter int NBITS           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_db,
    output logic [NBITS-1:0] rise,
    output logic [NBITS-1:0] fall,
    swi_debouncer_if.master  evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PEND
    } evt_state_t;

    logic [SYNC_STAGES-1:0][NBITS-1:0] sync_q;
    logic [NBITS-1:0]                  s;

    logic [NBITS-1:0][CW-1:0] cnt_q;
    logic [NBITS-1:0][CW-1:0] cnt_d;
    logic [NBITS-1:0]         db_d;
    logic [NBITS-1:0]         rise_d;
    logic [NBITS-1:0]         fall_d;

    evt_state_t       state_q;
    evt_state_t       state_d;
    logic [NBITS-1:0] bits_q;
    logic [NBITS-1:0] bits_d;
    logic [NBITS-1:0] chg_q;
    logic [NBITS-1:0] chg_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [NBITS-1:0] m;
    logic             acc;

    // Index 0 is the newest sample; the last stage is the metastability-safe one.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], swi_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d  = cnt_q;
        db_d   = swi_db;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NBITS; i++) begin
            if (s[i] == swi_db[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]   = s[i];
                cnt_d[i]  = '0;
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Pulses are registered alongside swi_db so they line up with the new level.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            swi_db <= '0;
            rise   <= '0;
            fall   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            swi_db <= db_d;
            rise   <= rise_d;
            fall   <= fall_d;
        end
    end

    assign m   = rise | fall;
    assign acc = (state_q == PEND) & evt.evt_ready;

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        chg_d   = chg_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (|m) begin
                    state_d = PEND;
                    bits_d  = swi_db;
                    chg_d   = m;
                    ovf_d   = 1'b0;
                end
            end
            PEND: begin
                if (acc) begin
                    if (|m) begin
                        bits_d = swi_db;
                        chg_d  = m;
                        ovf_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        bits_d  = '0;
                        chg_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end else if (|m) begin
                    // Unaccepted event absorbs the new change instead of dropping it.
                    bits_d = swi_db;
                    chg_d  = chg_q | m;
                    ovf_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bits_q  <= '0;
            chg_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            chg_q   <= chg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt.evt_valid    = (state_q == PEND);
    assign evt.evt_bits     = bits_q;
    assign evt.evt_changed  = chg_q;
    assign evt.evt_overflow = ovf_q;

endmodule

// File: tb/tb_swi_debouncer.sv
// Bench for swi_debouncer: directed scenarios with literal expectations
// plus randomized bouncing inputs checked every cycle against a model.
module tb_swi_debouncer;

    localparam int NB   = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic          clk_2 = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] swi_raw = '0;
    logic [NB-1:0] swi_db;
    logic [NB-1:0] rise;
    logic [NB-1:0] fall;
    logic          evt_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    swi_debouncer_if #(.NBITS(NB)) evt_if ();
    assign evt_if.evt_ready = evt_ready;

    swi_debouncer #(
        .NBITS(NB),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_2(clk_2),
        .rst_n(rst_n),
        .swi_raw(swi_raw),
        .swi_db(swi_db),
        .rise(rise),
        .fall(fall),
        .evt(evt_if)
    );

    always #5 clk_2 = ~clk_2;

    // Model state: the debounced level flips once the synchronised input has
    // disagreed with it for DEB consecutive edges; events count change cycles.
    typedef struct {
        logic [NB-1:0] db;
        logic [NB-1:0] rise;
        logic [NB-1:0] fall;
        logic          pend;
        logic [NB-1:0] bits;
        logic [NB-1:0] chg;
        int            nchg;
        int            run [NB];
    } mstate_t;

    mstate_t       ms;
    logic [NB-1:0] hist [64];
    int            cyc;
    logic [NB-1:0] s_m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.db   = '0;
        r.rise = '0;
        r.fall = '0;
        r.pend = 1'b0;
        r.bits = '0;
        r.chg  = '0;
        r.nchg = 0;
        for (int i = 0; i < NB; i++) r.run[i] = 0;
        return r;
    endfunction

    function automatic mstate_t model_step(mstate_t c, logic [NB-1:0] s,
                                           logic rdy);
        mstate_t       n;
        logic [NB-1:0] mm;
        n  = c;
        mm = c.rise | c.fall;
        if (c.pend && rdy) begin
            if (mm != '0) begin
                n.bits = c.db;
                n.chg  = mm;
                n.nchg = 1;
            end else begin
                n.pend = 1'b0;
                n.bits = '0;
                n.chg  = '0;
                n.nchg = 0;
            end
        end else if (!c.pend) begin
            if (mm != '0) begin
                n.pend = 1'b1;
                n.bits = c.db;
                n.chg  = mm;
                n.nchg = 1;
            end
        end else if (mm != '0) begin
            n.bits = c.db;
            n.chg  = c.chg | mm;
            n.nchg = c.nchg + 1;
        end
        n.rise = '0;
        n.fall = '0;
        for (int i = 0; i < NB; i++) begin
            if (s[i] != c.db[i]) begin
                n.run[i] = c.run[i] + 1;
                if (n.run[i] >= DEB) begin
                    n.db[i]  = s[i];
                    n.run[i] = 0;
                    if (s[i]) n.rise[i] = 1'b1;
                    else n.fall[i] = 1'b1;
                end
            end else begin
                n.run[i] = 0;
            end
        end
        return n;
    endfunction

    // The raw level seen by the filter is the one sampled SYNC edges earlier.
    always_comb begin
        s_m = '0;
        if (cyc >= SYNC) s_m = hist[(cyc - SYNC) % 64];
    end

    always @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            ms  <= model_reset();
            cyc <= 0;
        end else begin
            ms              <= model_step(ms, s_m, evt_ready);
            hist[cyc % 64]  <= swi_raw;
            cyc             <= cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [NB-1:0] got,
                       input logic [NB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp,
                     $time);
        end
    endtask

    always @(posedge clk_2) begin
        #2;
        chk("cmp_swi_db", swi_db, ms.db);
        chk("cmp_rise", rise, ms.rise);
        chk("cmp_fall", fall, ms.fall);
        chk("cmp_valid", NB'(evt_if.evt_valid), NB'(ms.pend));
        chk("cmp_bits", evt_if.evt_bits, ms.bits);
        chk("cmp_changed", evt_if.evt_changed, ms.chg);
        chk("cmp_overflow", NB'(evt_if.evt_overflow), NB'(ms.nchg > 1));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_2);
            #3;
        end
    endtask

    task automatic accept();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    initial begin
        // 1: reset with switches high, then the full latency to swi_db
        swi_raw = 8'hFF;
        step(2);
        chk("t1_rst_db", swi_db, 8'h00);
        chk("t1_rst_rise", rise, 8'h00);
        chk("t1_rst_valid", NB'(evt_if.evt_valid), 8'h00);
        chk("t1_rst_changed", evt_if.evt_changed, 8'h00);
        rst_n = 1'b1;
        step(5);
        chk("t1_edge5_db", swi_db, 8'h00);
        step();
        chk("t1_edge6_db", swi_db, 8'hFF);
        chk("t1_edge6_rise", rise, 8'hFF);
        step();
        chk("t1_rise_gone", rise, 8'h00);
        chk("t1_valid", NB'(evt_if.evt_valid), 8'h01);
        chk("t1_bits", evt_if.evt_bits, 8'hFF);
        chk("t1_changed", evt_if.evt_changed, 8'hFF);
        chk("t1_ovf", NB'(evt_if.evt_overflow), 8'h00);

        // 3: single-cycle accept with no new change clears the event
        accept();
        chk("t3_valid", NB'(evt_if.evt_valid), 8'h00);
        chk("t3_bits", evt_if.evt_bits, 8'h00);
        chk("t3_changed", evt_if.evt_changed, 8'h00);

        rst_n   = 1'b0;
        swi_raw = 8'h00;
        step(2);
        rst_n = 1'b1;
        step(3);

        // 2: a 3-cycle glitch is filtered out
        swi_raw = 8'h01;
        step(3);
        swi_raw = 8'h00;
        step(10);
        chk("t2_db", swi_db, 8'h00);
        chk("t2_valid", NB'(evt_if.evt_valid), 8'h00);

        // 4: two changes coalesce while nobody accepts
        swi_raw = 8'h02;
        step(10);
        swi_raw = 8'h06;
        step(10);
        chk("t4_valid", NB'(evt_if.evt_valid), 8'h01);
        chk("t4_changed", evt_if.evt_changed, 8'h06);
        chk("t4_bits", evt_if.evt_bits, 8'h06);
        chk("t4_ovf", NB'(evt_if.evt_overflow), 8'h01);
        accept();
        chk("t4_acc_valid", NB'(evt_if.evt_valid), 8'h00);
        chk("t4_acc_ovf", NB'(evt_if.evt_overflow), 8'h00);

        // 5: accept in the same cycle a new pulse arrives reloads the event
        swi_raw = 8'h07;
        step();
        swi_raw = 8'h0F;
        step(6);
        chk("t5_pre_rise", rise, 8'h08);
        chk("t5_pre_valid", NB'(evt_if.evt_valid), 8'h01);
        chk("t5_pre_changed", evt_if.evt_changed, 8'h01);
        accept();
        chk("t5_valid", NB'(evt_if.evt_valid), 8'h01);
        chk("t5_changed", evt_if.evt_changed, 8'h08);
        chk("t5_ovf", NB'(evt_if.evt_overflow), 8'h00);
        chk("t5_bits", evt_if.evt_bits, 8'h0F);
        accept();
        chk("t5_done_valid", NB'(evt_if.evt_valid), 8'h00);

        // 6: reset mid-debounce wipes state at once and restarts latency
        swi_raw = 8'h0E;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_db", swi_db, 8'h00);
        chk("t6_rst_valid", NB'(evt_if.evt_valid), 8'h00);
        chk("t6_rst_changed", evt_if.evt_changed, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("t6_edge5_db", swi_db, 8'h00);
        step();
        chk("t6_edge6_db", swi_db, 8'h0E);
        chk("t6_edge6_rise", rise, 8'h0E);

        // Random bouncing switches, random consumer, rare resets
        for (int k = 0; k < 3000; k++) begin
            int r;
            if (!rst_n) rst_n = 1'b1;
            r = $urandom_range(0, 15);
            if (r < 2) swi_raw = NB'($urandom);
            else if (r < 5) swi_raw = swi_raw ^ NB'(1 << $urandom_range(0, NB - 1));
            evt_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            step();
        end
        rst_n     = 1'b1;
        evt_ready = 1'b0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
